// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared encodings for the pipeline stall/flush scheduler.
//   state_t   - scheduler FSM state
//   REDIR_*   - redirect_sel encodings (exception vector / EPC)
//   REG_ZERO  - hard-wired zero register address
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIV_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    localparam logic       REDIR_EXC = 1'b0;
    localparam logic       REDIR_EPC = 1'b1;
    localparam logic [4:0] REG_ZERO  = 5'd0;

endpackage

// File: rtl/pipe_hazard_detect.sv
// pipe_hazard_detect: combinational load-use hazard compare.
//   id_rs/id_rt, id_uses_rs/id_uses_rt : ID-stage source operands
//   ex_is_load, ex_rf_we, ex_rd        : EX-stage producer
//   hz                                 : ID consumes the value a load in EX has not yet produced
module pipe_hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic       ex_is_load,
    input  logic       ex_rf_we,
    input  logic [4:0] ex_rd,
    output logic       hz
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = id_uses_rs && (id_rs == ex_rd);
    assign rt_hit = id_uses_rt && (id_rt == ex_rd);

    // $0 is never actually written, so it can never be a true dependency.
    assign hz = ex_is_load && ex_rf_we && (ex_rd != REG_ZERO) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall/flush scheduler for the 5-stage pipeline.
//   Sequences the multi-cycle divider, inserts load-use bubbles and drives the
//   exception/ERET flush of every segment register plus the PC redirect.
//   Priority per cycle: exception/ERET > divider > load-use.
// Parameters:
//   FLUSH_CYC - extra cycles flush_all stays high after the triggering cycle (0..7)
//   CNT_W     - performance counter width (PIPE_PERF_EN builds only)
// Ports:
//   clk, resetn (synchronous, active low)
//   id_*/ex_* hazard inputs, ex_div_req, div_done, mem_cp0_ex, mem_eret_flush
//   if/id/ex/mem_stall, id_flush, flush_all, div_start/cancel/finish,
//   pc_redirect, redirect_sel
// Optional macro PIPE_PERF_EN: adds saturating div_stall_cnt, lu_stall_cnt,
//   flush_cnt outputs.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYC = 1,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_is_load,
    input  logic             ex_rf_we,
    input  logic [4:0]       ex_rd,
    input  logic             ex_div_req,
    input  logic             div_done,
    input  logic             mem_cp0_ex,
    input  logic             mem_eret_flush,
    output logic             if_stall,
    output logic             id_stall,
    output logic             ex_stall,
    output logic             mem_stall,
    output logic             id_flush,
    output logic             flush_all,
    output logic             div_start,
    output logic             div_cancel,
    output logic             div_finish,
    output logic             pc_redirect,
    output logic             redirect_sel
`ifdef PIPE_PERF_EN
    ,
    output logic [CNT_W-1:0] div_stall_cnt,
    output logic [CNT_W-1:0] lu_stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    state_t     state, state_nxt;
    logic [2:0] fcnt, fcnt_nxt;
    logic       hz;
    logic       exc;

    assign exc = mem_cp0_ex || mem_eret_flush;

    pipe_hazard_detect u_hz (
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rs (id_uses_rs),
        .id_uses_rt (id_uses_rt),
        .ex_is_load (ex_is_load),
        .ex_rf_we   (ex_rf_we),
        .ex_rd      (ex_rd),
        .hz         (hz)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            fcnt  <= 3'd0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        fcnt_nxt     = fcnt;
        if_stall     = 1'b0;
        id_stall     = 1'b0;
        ex_stall     = 1'b0;
        mem_stall    = 1'b0;
        id_flush     = 1'b0;
        flush_all    = 1'b0;
        div_start    = 1'b0;
        div_cancel   = 1'b0;
        div_finish   = 1'b0;
        pc_redirect  = 1'b0;
        redirect_sel = REDIR_EXC;

        // Outputs are forced quiet during reset; the divider is reset by
        // resetn itself, so no cancel is needed even mid-divide.
        if (resetn) begin
            if (state == FLUSH) begin
                // Drain in-flight RAM reads; everything else is ignored.
                flush_all = 1'b1;
                if (fcnt <= 3'd1) begin
                    state_nxt = IDLE;
                    fcnt_nxt  = 3'd0;
                end else begin
                    fcnt_nxt  = fcnt - 3'd1;
                end
            end else if (exc) begin
                flush_all    = 1'b1;
                pc_redirect  = 1'b1;
                redirect_sel = (mem_eret_flush && !mem_cp0_ex) ? REDIR_EPC : REDIR_EXC;
                div_cancel   = (state == DIV_WAIT);
                if (FLUSH_CYC > 0) begin
                    state_nxt = FLUSH;
                    fcnt_nxt  = 3'(FLUSH_CYC);
                end else begin
                    state_nxt = IDLE;
                    fcnt_nxt  = 3'd0;
                end
            end else if (state == DIV_WAIT) begin
                if (div_done) begin
                    // Div leaves EX at this edge, so IDLE never relaunches it.
                    div_finish = 1'b1;
                    state_nxt  = IDLE;
                end else begin
                    if_stall  = 1'b1;
                    id_stall  = 1'b1;
                    ex_stall  = 1'b1;
                    mem_stall = 1'b1;
                end
            end else if (ex_div_req) begin
                div_start = 1'b1;
                if_stall  = 1'b1;
                id_stall  = 1'b1;
                ex_stall  = 1'b1;
                mem_stall = 1'b1;
                state_nxt = DIV_WAIT;
            end else if (hz) begin
                if_stall = 1'b1;
                id_stall = 1'b1;
                id_flush = 1'b1;
            end
        end
    end

`ifdef PIPE_PERF_EN
    logic div_cyc;
    assign div_cyc = resetn && ((state == DIV_WAIT) || div_start);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            div_stall_cnt <= '0;
            lu_stall_cnt  <= '0;
            flush_cnt     <= '0;
        end else begin
            if (div_cyc && (div_stall_cnt != '1)) div_stall_cnt <= div_stall_cnt + CNT_W'(1);
            if (id_flush && (lu_stall_cnt != '1)) lu_stall_cnt <= lu_stall_cnt + CNT_W'(1);
            if (flush_all && (flush_cnt != '1))   flush_cnt     <= flush_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl. A stimulus process drives one
// input vector per cycle and pushes the reference model's expected outputs;
// a monitor pops and compares at the falling edge.
module tb_pipe_ctrl;

    localparam int FLUSH_CYC = 1;
    localparam int CNT_W     = 32;

    typedef struct {
        logic       rn;
        logic [4:0] rs, rt, rd;
        logic       urs, urt, ld, we, dreq, ddone, cp0, eret;
    } stim_t;

    typedef struct {
        int          cyc;
        logic [10:0] o;
        logic [31:0] c0, c1, c2;
    } exp_t;

    logic clk = 1'b0;
    logic resetn;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic id_uses_rs, id_uses_rt, ex_is_load, ex_rf_we, ex_div_req, div_done;
    logic mem_cp0_ex, mem_eret_flush;
    logic if_stall, id_stall, ex_stall, mem_stall, id_flush, flush_all;
    logic div_start, div_cancel, div_finish, pc_redirect, redirect_sel;
`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0] div_stall_cnt, lu_stall_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

    pipe_ctrl #(.FLUSH_CYC(FLUSH_CYC), .CNT_W(CNT_W)) dut (
        .clk(clk), .resetn(resetn),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_is_load(ex_is_load), .ex_rf_we(ex_rf_we), .ex_rd(ex_rd),
        .ex_div_req(ex_div_req), .div_done(div_done),
        .mem_cp0_ex(mem_cp0_ex), .mem_eret_flush(mem_eret_flush),
        .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall), .mem_stall(mem_stall),
        .id_flush(id_flush), .flush_all(flush_all),
        .div_start(div_start), .div_cancel(div_cancel), .div_finish(div_finish),
        .pc_redirect(pc_redirect), .redirect_sel(redirect_sel)
`ifdef PIPE_PERF_EN
        , .div_stall_cnt(div_stall_cnt), .lu_stall_cnt(lu_stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Reference model state: is a divide outstanding, and how many drain
    // cycles of flushing remain.
    bit          m_busy  = 0;
    int          m_flush = 0;
    logic [31:0] m_c0 = 0, m_c1 = 0, m_c2 = 0;

    function automatic stim_t idle_s();
        stim_t s;
        s.rn = 1; s.rs = 0; s.rt = 0; s.rd = 0;
        s.urs = 0; s.urt = 0; s.ld = 0; s.we = 0;
        s.dreq = 0; s.ddone = 0; s.cp0 = 0; s.eret = 0;
        return s;
    endfunction

    function automatic logic [31:0] sat(input logic [31:0] v);
        return (v == 32'hffff_ffff) ? v : v + 1;
    endfunction

    task automatic issue(input stim_t s);
        exp_t e;
        bit st_if, st_id, st_ex, st_mem, fl, fa, ds, dc, df, pr, rsel, hz;
        bit divcyc;
        @(posedge clk);
        #1;
        resetn = s.rn; id_rs = s.rs; id_rt = s.rt; ex_rd = s.rd;
        id_uses_rs = s.urs; id_uses_rt = s.urt; ex_is_load = s.ld; ex_rf_we = s.we;
        ex_div_req = s.dreq; div_done = s.ddone; mem_cp0_ex = s.cp0; mem_eret_flush = s.eret;

        {st_if, st_id, st_ex, st_mem, fl, fa, ds, dc, df, pr, rsel} = '0;
        hz = s.ld && s.we && s.rd != 0 &&
             ((s.urs && s.rs == s.rd) || (s.urt && s.rt == s.rd));
        divcyc = 0;
        e.cyc = cyc; e.c0 = m_c0; e.c1 = m_c1; e.c2 = m_c2;

        if (!s.rn) begin
            m_busy = 0; m_flush = 0; m_c0 = 0; m_c1 = 0; m_c2 = 0;
        end else begin
            if (m_flush > 0) begin
                fa = 1; m_flush--;
            end else if (s.cp0 || s.eret) begin
                fa = 1; pr = 1; rsel = s.eret && !s.cp0; dc = m_busy;
                divcyc = m_busy;
                m_busy = 0; m_flush = FLUSH_CYC;
            end else if (m_busy) begin
                divcyc = 1;
                if (s.ddone) begin df = 1; m_busy = 0; end
                else {st_if, st_id, st_ex, st_mem} = 4'hf;
            end else if (s.dreq) begin
                ds = 1; {st_if, st_id, st_ex, st_mem} = 4'hf; m_busy = 1; divcyc = 1;
            end else if (hz) begin
                st_if = 1; st_id = 1; fl = 1;
            end
            if (divcyc) m_c0 = sat(m_c0);
            if (fl)     m_c1 = sat(m_c1);
            if (fa)     m_c2 = sat(m_c2);
        end
        e.o = {st_if, st_id, st_ex, st_mem, fl, fa, ds, dc, df, pr, rsel};
        exp_q.push_back(e);
        cyc++;
    endtask

    // Monitor: every cycle with a pending expectation is compared.
    initial begin
        exp_t e;
        logic [10:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act = {if_stall, id_stall, ex_stall, mem_stall, id_flush, flush_all,
                       div_start, div_cancel, div_finish, pc_redirect, redirect_sel};
                total++;
                if (act !== e.o) begin
                    bad++;
                    $display("FAIL outputs cyc=%0d got=%b want=%b (if id ex mem idfl fall st cn fin pr sel)",
                             e.cyc, act, e.o);
                end
`ifdef PIPE_PERF_EN
                total++;
                if (div_stall_cnt !== e.c0 || lu_stall_cnt !== e.c1 || flush_cnt !== e.c2) begin
                    bad++;
                    $display("FAIL perf_cnt cyc=%0d got=%0d/%0d/%0d want=%0d/%0d/%0d", e.cyc,
                             div_stall_cnt, lu_stall_cnt, flush_cnt, e.c0, e.c1, e.c2);
                end
`endif
            end
        end
    end

    initial begin
        stim_t s;
        resetn = 0; id_rs = 0; id_rt = 0; ex_rd = 0; id_uses_rs = 0; id_uses_rt = 0;
        ex_is_load = 0; ex_rf_we = 0; ex_div_req = 0; div_done = 0;
        mem_cp0_ex = 0; mem_eret_flush = 0;

        // Reset, then idle.
        s = idle_s(); s.rn = 0; issue(s); issue(s);
        s = idle_s(); issue(s);

        // Load-use hit on rs, then the same with $0.
        s = idle_s(); s.ld = 1; s.we = 1; s.rd = 5; s.rs = 5; s.urs = 1; issue(s);
        s.rd = 0; s.rs = 0; issue(s);
        s = idle_s(); s.ld = 1; s.we = 1; s.rd = 7; s.rt = 7; s.urt = 1; issue(s);
        s = idle_s(); issue(s);

        // Divide: request at cycle 0, done at cycle 33.
        for (int i = 0; i <= 33; i++) begin
            s = idle_s(); s.dreq = 1; s.ddone = (i == 33); issue(s);
        end
        s = idle_s(); issue(s);

        // Exception at cycle 10 of DIV_WAIT, then a late div_done.
        for (int i = 0; i <= 10; i++) begin
            s = idle_s(); s.dreq = 1; s.cp0 = (i == 10); issue(s);
        end
        s = idle_s(); s.cp0 = 1; issue(s);
        s = idle_s(); s.ddone = 1; issue(s);
        s = idle_s(); issue(s);

        // ERET vs exception redirect select.
        s = idle_s(); s.cp0 = 1; s.eret = 1; issue(s);
        s = idle_s(); issue(s);
        s = idle_s(); s.eret = 1; issue(s);
        s = idle_s(); issue(s);

        // Divider beats load-use in the same cycle.
        s = idle_s(); s.ld = 1; s.we = 1; s.rd = 3; s.rs = 3; s.urs = 1; s.dreq = 1; issue(s);
        s = idle_s(); s.dreq = 1; s.ddone = 1; issue(s);

        // Reset for one cycle mid-divide.
        s = idle_s(); s.dreq = 1; issue(s); issue(s);
        s.rn = 0; issue(s);
        s = idle_s(); issue(s);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            s = idle_s();
            s.rn    = ($urandom_range(0, 149) != 0);
            s.rs    = 5'($urandom_range(0, 3));
            s.rt    = 5'($urandom_range(0, 3));
            s.rd    = 5'($urandom_range(0, 3));
            s.urs   = 1'($urandom);
            s.urt   = 1'($urandom);
            s.ld    = 1'($urandom);
            s.we    = ($urandom_range(0, 3) != 0);
            s.dreq  = m_busy ? 1'b1 : ($urandom_range(0, 7) == 0);
            s.ddone = ($urandom_range(0, 11) == 0);
            s.cp0   = ($urandom_range(0, 24) == 0);
            s.eret  = ($urandom_range(0, 24) == 0);
            issue(s);
        end

        repeat (2) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d pending want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
